// File: rtl/uart_line_arbiter_if.sv
// Handshake bundle between NUM_REQ line producers and the shared console output.
interface uart_line_arbiter_if #(parameter int NUM_REQ = 4);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   in_valid;
    logic [8*NUM_REQ-1:0] in_ch;
    logic [NUM_REQ-1:0]   in_ready;
    logic                 out_valid;
    logic [7:0]           out_ch;
    logic                 out_ready;
    logic [ID_W-1:0]      out_id;

    modport master (
        output in_valid, in_ch, out_ready,
        input  in_ready, out_valid, out_ch, out_id
    );
    modport slave (
        input  in_valid, in_ch, out_ready,
        output in_ready, out_valid, out_ch, out_id
    );
endinterface

// File: rtl/uart_line_arbiter.sv
// Round-robin, line-granular console arbiter: each grant drains one whole line from one requester.
// Define UART_ARB_PREFIX_EN to precede every granted line with "[<id>] ".

module uart_line_fifo #(parameter int LINE_DEPTH = 16) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_ch,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       line_ready
);
    localparam int AW = $clog2(LINE_DEPTH);

    logic [7:0]  mem [LINE_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, nl;
    logic        nl_inc, nl_dec;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign full       = (wr_ptr - rd_ptr) == (AW+1)'(LINE_DEPTH);
    assign nl_inc     = push && push_ch == 8'h0A;
    assign nl_dec     = pop && head == 8'h0A;
    // A full buffer without a newline is still drained so the writer cannot stall forever.
    assign line_ready = nl != '0 || full;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_ch;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            nl     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (nl_inc && !nl_dec)      nl <= nl + 1'b1;
            else if (!nl_inc && nl_dec) nl <= nl - 1'b1;
        end
    end
endmodule

module uart_line_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LINE_DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    uart_line_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LINE_DEPTH) + 1;

`ifdef UART_ARB_PREFIX_EN
    typedef enum logic [1:0] {IDLE, PREFIX, DRAIN} state_t;
    logic [1:0] pcnt, pcnt_n;
`else
    typedef enum logic [0:0] {IDLE, DRAIN} state_t;
`endif

    state_t                  state, state_n;
    logic [ID_W-1:0]         grant, grant_n, last, last_n, pick, rr_idx;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    found, out_valid;
    logic [7:0]              out_ch;
    logic [NUM_REQ-1:0]      push, pop, full, line_ready;
    logic [NUM_REQ-1:0][7:0] head;
    int                      rr_j;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign push[i] = bus.in_valid[i] && !full[i] && reset_n;
        uart_line_fifo #(.LINE_DEPTH(LINE_DEPTH)) u_fifo (
            .clock      (clock),
            .reset_n    (reset_n),
            .push       (push[i]),
            .push_ch    (bus.in_ch[8*i +: 8]),
            .pop        (pop[i]),
            .head       (head[i]),
            .full       (full[i]),
            .line_ready (line_ready[i])
        );
    end

    assign bus.in_ready  = ~full & {NUM_REQ{reset_n}};
    assign bus.out_valid = out_valid;
    assign bus.out_ch    = out_ch;
    assign bus.out_id    = grant;

    // First line-ready requester after the last one served.
    always_comb begin
        pick   = last;
        found  = 1'b0;
        rr_j   = 0;
        rr_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_j = int'(last) + k;
            if (rr_j >= NUM_REQ) rr_j = rr_j - NUM_REQ;
            rr_idx = ID_W'(rr_j);
            if (!found && line_ready[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        last_n    = last;
        cnt_n     = cnt;
        pop       = '0;
        out_valid = 1'b0;
        out_ch    = 8'h00;
`ifdef UART_ARB_PREFIX_EN
        pcnt_n    = pcnt;
`endif
        case (state)
            IDLE: if (found) begin
                grant_n = pick;
                last_n  = pick;
                cnt_n   = '0;
`ifdef UART_ARB_PREFIX_EN
                pcnt_n  = '0;
                state_n = PREFIX;
`else
                state_n = DRAIN;
`endif
            end
`ifdef UART_ARB_PREFIX_EN
            PREFIX: begin
                out_valid = 1'b1;
                case (pcnt)
                    2'd0:    out_ch = 8'h5B;
                    2'd1:    out_ch = 8'h30 + 8'(grant);
                    2'd2:    out_ch = 8'h5D;
                    default: out_ch = 8'h20;
                endcase
                if (bus.out_ready) begin
                    pcnt_n = pcnt + 1'b1;
                    if (pcnt == 2'd3) state_n = DRAIN;
                end
            end
`endif
            DRAIN: begin
                out_valid = 1'b1;
                out_ch    = head[grant];
                if (bus.out_ready) begin
                    pop[grant] = 1'b1;
                    cnt_n      = cnt + 1'b1;
                    if (head[grant] == 8'h0A || cnt_n == CNT_W'(LINE_DEPTH)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= ID_W'(NUM_REQ - 1);
            cnt   <= '0;
`ifdef UART_ARB_PREFIX_EN
            pcnt  <= '0;
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            cnt   <= cnt_n;
`ifdef UART_ARB_PREFIX_EN
            pcnt  <= pcnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_line_arbiter.sv
// Self-checking bench for uart_line_arbiter: directed line scenarios plus a randomized run
// checked against a queue-based model of per-requester buffers and round-robin line grants.
`timescale 1ns/1ps
module tb_uart_line_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int LINE_DEPTH = 16;
    localparam int ID_W       = $clog2(NUM_REQ);
`ifdef UART_ARB_PREFIX_EN
    localparam int PFX = 4;
`else
    localparam int PFX = 0;
`endif

    typedef logic [7:0] bq_t [$];

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   passed  = 0;

    logic [7:0]      log_ch  [$];
    logic [ID_W-1:0] log_id  [$];
    int              log_cyc [$];

    uart_line_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_line_arbiter #(.NUM_REQ(NUM_REQ), .LINE_DEPTH(LINE_DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            log_ch.push_back(bus.out_ch);
            log_id.push_back(bus.out_id);
            log_cyc.push_back(cyc);
        end
    end

    function automatic bq_t exp_line(input int id, input string s);
        bq_t r;
`ifdef UART_ARB_PREFIX_EN
        r.push_back(8'h5B);
        r.push_back(8'(8'h30 + id));
        r.push_back(8'h5D);
        r.push_back(8'h20);
`endif
        for (int k = 0; k < s.len(); k++) r.push_back(s[k]);
        return r;
    endfunction

    task automatic clear_log();
        log_ch.delete();
        log_id.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset_n       = 1'b0;
        bus.in_valid  = '0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // One byte per cycle per requester; c_last is the cycle of the final byte.
    task automatic send2(input int ia, input string sa, input int ib, input string sb, output int c_last);
        int n;
        n = (sa.len() > sb.len()) ? sa.len() : sb.len();
        c_last = cyc;
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            bus.in_valid = '0;
            if (k < sa.len()) begin
                bus.in_valid[ia]      = 1'b1;
                bus.in_ch[8*ia +: 8]  = sa[k];
            end
            if (ib >= 0 && k < sb.len()) begin
                bus.in_valid[ib]      = 1'b1;
                bus.in_ch[8*ib +: 8]  = sb[k];
            end
            c_last = cyc;
        end
        @(posedge clock); #1;
        bus.in_valid = '0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 4'b0001;
        bus.in_ch     = {4{8'h0A}};
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_ch !== 8'h00) $display("FAIL reset_out_ch: got %h want 00", bus.out_ch); else passed++;
        checks++; if (bus.out_id !== '0) $display("FAIL reset_out_id: got %0d want 0", bus.out_id); else passed++;
        checks++; if (bus.in_ready !== '0) $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); else passed++;
        @(posedge clock); #1;
        reset_n      = 1'b1;
        bus.in_valid = '0;
        clear_log();
        repeat (6) @(posedge clock);
        @(negedge clock);
        checks++; if (log_ch.size() != 0) $display("FAIL reset_no_output: got %0d bytes want 0", log_ch.size()); else passed++;
        checks++; if (bus.in_ready !== '1) $display("FAIL reset_release_ready: got %b want 1111", bus.in_ready); else passed++;
    endtask

    task automatic test_single_line();
        bq_t e;
        int  c;
        do_reset();
        clear_log();
        send2(2, "ok\n", -1, "", c);
        repeat (12) @(posedge clock);
        @(negedge clock);
        e = exp_line(2, "ok\n");
        checks++; if (log_ch.size() != e.size()) $display("FAIL single_len: got %0d want %0d", log_ch.size(), e.size()); else passed++;
        for (int k = 0; k < e.size() && k < log_ch.size(); k++) begin
            checks++;
            if (log_ch[k] !== e[k] || log_id[k] !== ID_W'(2) || log_cyc[k] != c + 2 + k)
                $display("FAIL single_byte%0d: got %h id %0d cyc %0d want %h id 2 cyc %0d", k, log_ch[k], log_id[k], log_cyc[k], e[k], c + 2 + k);
            else passed++;
        end
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_after: out_valid %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_round_robin();
        bq_t e0, e1;
        int  c, n;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            clear_log();
            send2(0, "A\n", 1, "B\n", c);
            repeat (16) @(posedge clock);
            @(negedge clock);
            e0 = exp_line(0, "A\n");
            e1 = exp_line(1, "B\n");
            n  = e0.size();
            checks++; if (log_ch.size() != 2 * n) $display("FAIL rr_len%0d: got %0d want %0d", rep, log_ch.size(), 2 * n); else passed++;
            for (int k = 0; k < 2 * n && k < log_ch.size(); k++) begin
                checks++;
                if (log_ch[k] !== (k < n ? e0[k] : e1[k-n]) || log_id[k] !== ID_W'(k < n ? 0 : 1) ||
                    log_cyc[k] != c + 2 + k + (k < n ? 0 : 1))
                    $display("FAIL rr%0d_byte%0d: got %h id %0d cyc %0d want %h id %0d cyc %0d", rep, k, log_ch[k], log_id[k],
                             log_cyc[k], (k < n ? e0[k] : e1[k-n]), (k < n ? 0 : 1), c + 2 + k + (k < n ? 0 : 1));
                else passed++;
            end
        end
    endtask

    task automatic test_forced_line();
        int c;
        do_reset();
        clear_log();
        send2(3, "AAAAAAAAAAAAAAAA", -1, "", c);
        @(negedge clock);
        checks++; if (bus.in_ready[3] !== 1'b0) $display("FAIL full_ready_drop: got %b want 0", bus.in_ready[3]); else passed++;
        for (int k = 1; k <= 1 + PFX; k++) begin
            @(negedge clock);
            checks++; if (bus.in_ready[3] !== 1'b0) $display("FAIL full_ready_hold%0d: got %b want 0", k, bus.in_ready[3]); else passed++;
        end
        @(negedge clock);
        checks++; if (bus.in_ready[3] !== 1'b1) $display("FAIL full_ready_rise: got %b want 1", bus.in_ready[3]); else passed++;
        repeat (24) @(posedge clock);
        @(negedge clock);
        checks++; if (log_ch.size() != LINE_DEPTH + PFX) $display("FAIL forced_len: got %0d want %0d", log_ch.size(), LINE_DEPTH + PFX); else passed++;
        for (int k = PFX; k < log_ch.size(); k++) begin
            checks++;
            if (log_ch[k] !== 8'h41 || log_id[k] !== ID_W'(3) || log_cyc[k] != c + 2 + k)
                $display("FAIL forced_byte%0d: got %h id %0d cyc %0d want 41 id 3 cyc %0d", k, log_ch[k], log_id[k], log_cyc[k], c + 2 + k);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        bq_t e;
        int  c, p;
        do_reset();
        clear_log();
        send2(1, "xy\n", -1, "", c);
        for (int r = 0; r < 8 + PFX; r++) begin
            @(posedge clock); #1;
            p = r - PFX;
            bus.out_ready = !(p == 1 || p == 2);
            @(negedge clock);
            if (p >= 1 && p <= 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_ch !== 8'h79)
                    $display("FAIL bp_hold%0d: got valid %b ch %h want 1 79", p, bus.out_valid, bus.out_ch);
                else passed++;
            end
        end
        bus.out_ready = 1'b1;
        e = exp_line(1, "xy\n");
        checks++; if (log_ch.size() != e.size()) $display("FAIL bp_len: got %0d want %0d", log_ch.size(), e.size()); else passed++;
        for (int k = 0; k < e.size() && k < log_ch.size(); k++) begin
            checks++;
            if (log_ch[k] !== e[k] || log_id[k] !== ID_W'(1))
                $display("FAIL bp_byte%0d: got %h id %0d want %h id 1", k, log_ch[k], log_id[k], e[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_midline();
        bq_t e;
        int  c;
        do_reset();
        clear_log();
        send2(1, "hello\n", -1, "", c);
        repeat (3 + PFX) @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_id !== '0) $display("FAIL midreset_id: got %0d want 0", bus.out_id); else passed++;
        checks++; if (log_ch.size() != 2 + PFX) $display("FAIL midreset_partial: got %0d bytes want %0d", log_ch.size(), 2 + PFX); else passed++;
        clear_log();
        repeat (10) @(posedge clock);
        @(negedge clock);
        checks++; if (log_ch.size() != 0) $display("FAIL midreset_discard: got %0d bytes want 0", log_ch.size()); else passed++;
        send2(0, "z\n", -1, "", c);
        repeat (12) @(posedge clock);
        @(negedge clock);
        e = exp_line(0, "z\n");
        checks++; if (log_ch.size() != e.size()) $display("FAIL midreset_len: got %0d want %0d", log_ch.size(), e.size()); else passed++;
        for (int k = 0; k < e.size() && k < log_ch.size(); k++) begin
            checks++;
            if (log_ch[k] !== e[k] || log_id[k] !== ID_W'(0))
                $display("FAIL midreset_byte%0d: got %h id %0d want %h id 0", k, log_ch[k], log_id[k], e[k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [7:0]         q [NUM_REQ][$];
        bq_t                m_line;
        logic [NUM_REQ-1:0] exp_rdy;
        int                 m_id, m_last, m_pfx, j;
        bit                 m_busy, hit;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) q[i].delete();
        m_busy = 1'b0; m_id = 0; m_last = NUM_REQ - 1; m_pfx = 0;
        for (int t = 0; t < 1600 && (checks - passed) < 20; t++) begin
            if (t > 0) begin @(posedge clock); #1; end
            bus.out_ready = (t >= 1400) || ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.in_valid[i]     = (t < 1400) && ($urandom_range(0, 99) < 30);
                bus.in_ch[8*i +: 8] = ($urandom_range(0, 9) == 0) ? 8'h0A : 8'(8'h61 + $urandom_range(0, 25));
            end
            @(negedge clock);
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_rdy[i] = q[i].size() < LINE_DEPTH;
                checks++;
                if (bus.in_ready[i] !== exp_rdy[i]) $display("FAIL rand_ready t%0d r%0d: got %b want %b", t, i, bus.in_ready[i], exp_rdy[i]);
                else passed++;
            end
            if (m_busy) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_id !== ID_W'(m_id) || bus.out_ch !== m_line[0])
                    $display("FAIL rand_out t%0d: got valid %b id %0d ch %h want 1 id %0d ch %h", t, bus.out_valid, bus.out_id, bus.out_ch, m_id, m_line[0]);
                else passed++;
                if (bus.out_ready) begin
                    if (m_pfx > 0) m_pfx--;
                    else void'(q[m_id].pop_front());
                    void'(m_line.pop_front());
                    if (m_line.size() == 0) m_busy = 1'b0;
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.out_id !== ID_W'(m_id))
                    $display("FAIL rand_idle t%0d: got valid %b id %0d want 0 id %0d", t, bus.out_valid, bus.out_id, m_id);
                else passed++;
                for (int k = 1; k <= NUM_REQ && !m_busy; k++) begin
                    j   = (m_last + k) % NUM_REQ;
                    hit = (q[j].size() == LINE_DEPTH);
                    for (int n = 0; n < q[j].size(); n++) if (q[j][n] == 8'h0A) hit = 1'b1;
                    if (hit) begin
                        m_busy = 1'b1; m_id = j; m_last = j; m_pfx = PFX;
                        m_line = exp_line(j, "");
                        for (int n = 0; n < q[j].size() && n < LINE_DEPTH; n++) begin
                            m_line.push_back(q[j][n]);
                            if (q[j][n] == 8'h0A) break;
                        end
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.in_valid[i] && exp_rdy[i]) q[i].push_back(bus.in_ch[8*i +: 8]);
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_round_robin();
        test_forced_line();
        test_backpressure();
        test_reset_midline();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
